fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the lx32 core: owns the fetch PC, issues in-order requests to instruction memory, and buffers returned words with their PCs in a small reservation queue. It presents `{pc, instr}` to the decode stage, where `imm_gen` and the decoder consume `instr`. It accepts redirects from execute for taken branches and jumps, and drops stale in-flight responses after a redirect.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch PC after reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, default 4: reservation queue slots; power of two, ≥2.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response valid. Responses arrive in order, always accepted, no earlier than 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and forced to 0.
- `if_valid` out 1: decode output valid.
- `if_ready` in 1: decode accepts.
- `if_pc` out 32: PC of the presented instruction.
- `if_instr` out 32: presented instruction word.

## Operation
- `fetch_pc` register: `imem_req_addr = fetch_pc`.
- On request acceptance (`imem_req_valid && imem_req_ready`): `fetch_pc += 4`, modulo 2^32, so 0xFFFF_FFFC wraps to 0. A queue slot at the tail is reserved with `pc = fetch_pc` and `filled = 0`.
- `imem_req_valid = !redirect_valid && (reserved < QUEUE_DEPTH || pop)`, where `pop = if_valid && if_ready`. This is a combinational path from `if_ready`.
- Response with `drop_cnt == 0`: writes `imem_rsp_data` into the oldest reserved, unfilled slot and sets its `filled` flag.
- Response with `drop_cnt > 0`: discarded, and `drop_cnt` decrements.
- `if_valid` is high when the head slot is reserved and filled. `if_pc` and `if_instr` come from the head slot.
- On `pop`: the head is freed and the head pointer advances, wrapping modulo `QUEUE_DEPTH`.
- On `redirect_valid`:
  - All slots are freed and the pointers reset.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - `drop_cnt <= outstanding - imem_rsp_valid`. A response in the redirect cycle belongs to the old stream and is discarded.
  - `pop` in the same cycle is ignored by the queue. Decode is flushed by the same redirect.
  - No request is issued in the redirect cycle.
- Counter widths: `outstanding` and `drop_cnt` are `$clog2(QUEUE_DEPTH)+1` bits. `outstanding` counts accepted requests without a response.
- Simultaneous reserve, fill, and pop in one cycle are all legal and independent.
- Counter values `reserved`, `outstanding`, and `drop_cnt` never exceed `QUEUE_DEPTH`.

## Timing
- Reset values:
  - `imem_req_valid` is combinational. It is high in the first post-reset cycle if no redirect is present.
  - `imem_req_addr = RESET_PC`.
  - `if_valid = 0`; `if_pc = 0`; `if_instr = 0`.
  - All slots free; `outstanding = 0`; `drop_cnt = 0`.
- Reset mid-operation discards all state immediately. Responses after reset are not expected; the memory is reset with the core.
- Latency:
  - Request accepted in cycle N.
  - Response in cycle N+k (k ≥ 1).
  - `if_valid` in cycle N+k+1. There is no response-to-output bypass.
- Throughput: one instruction per cycle sustained with k=1 and `QUEUE_DEPTH ≥ 2`, given the pop-frees-slot rule.
- Redirect in cycle R: first new-stream request in cycle R+1, at the redirect PC.
- Valid/ready: `if_pc` and `if_instr` stay stable while `if_valid && !if_ready`. The same holds for `imem_req_addr` while `imem_req_valid && !imem_req_ready`, unless a redirect occurs.

## Structure
- Add to `lx32_arch_pkg`: `PC_STEP = 4` and the `fetch_slot_t` struct `{logic filled; logic [31:0] pc; logic [31:0] instr;}`.
- Sub-module `fetch_queue`: the reservation queue, with reserve/fill/pop/flush ports, head outputs, and a `reserved` count.
- `fetch_unit` holds the PC, request control, the outstanding counter, and the drop counter.

## Test plan
- Reset with `RESET_PC = 0x100`, zero-wait memory, `if_ready = 1` → requests at 0x100, 0x104, 0x108…; `if_valid` from cycle 2, one instruction per cycle; `if_pc` matches each `if_instr`.
- `if_ready = 0` for 10 cycles → exactly 4 requests issued, `imem_req_valid` low after that; the held output stays stable. Releasing `if_ready` drains in order with no loss.
- Memory latency 3 with 2 requests outstanding, redirect to 0x2002 → `drop_cnt = 2`; both old responses discarded; next request at 0x2000; first `if_pc = 0x2000`.
- Redirect in the same cycle as a response and a pop → response dropped, pop ignored, `drop_cnt = outstanding - 1`, no request that cycle.
- `redirect_pc = 0xFFFF_FFFC` → requests at 0xFFFF_FFFC then 0x0000_0000.
- `rst_n` asserted mid-stream with 3 slots full → `if_valid = 0` immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/lx32_arch_pkg.sv
// lx32 architectural constants and shared stage types.
// No ports; imported by the fetch stage.
package lx32_arch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        filled;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_queue.sv
// Reservation queue: slots reserved in request order, filled in response order.
// Ports: reserve/fill/pop/flush controls, head_{valid,pc,instr}_o, reserved_o.
module fetch_queue
  import lx32_arch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     reserve_i,
  input  logic [31:0]              reserve_pc_i,
  input  logic                     fill_i,
  input  logic [31:0]              fill_data_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output logic [31:0]              head_pc_o,
  output logic [31:0]              head_instr_o,
  output logic [$clog2(DEPTH):0]   reserved_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_slot_t      slot_q [DEPTH];
  logic [DEPTH-1:0] used_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW-1:0]    fill_q;
  logic [CW-1:0]    cnt_q;

  // Responses return in request order, so the oldest unfilled slot
  // is tracked by its own pointer trailing the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      used_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      used_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pop_i) begin
        used_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (reserve_i) begin
        used_q[tail_q]        <= 1'b1;
        slot_q[tail_q].filled <= 1'b0;
        slot_q[tail_q].pc     <= reserve_pc_i;
        tail_q                <= tail_q + 1'b1;
      end
      if (fill_i) begin
        slot_q[fill_q].filled <= 1'b1;
        slot_q[fill_q].instr  <= fill_data_i;
        fill_q                <= fill_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(reserve_i) - CW'(pop_i);
    end
  end

  assign head_valid_o = used_q[head_q] & slot_q[head_q].filled;
  assign head_pc_o    = slot_q[head_q].pc;
  assign head_instr_o = slot_q[head_q].instr;
  assign reserved_o   = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem request control, stale-response drop, decode output.
// Ports: imem_req_*/imem_rsp_*, redirect_*, if_valid/if_ready/if_pc/if_instr.
module fetch_unit
  import lx32_arch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] reserved;
  logic          pop;
  logic          req_fire;
  logic          fill;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pop = if_valid & if_ready;

  // A pop frees a slot this cycle, so a full queue may still issue.
  assign imem_req_valid = !redirect_valid &&
                          ((reserved < CW'(QUEUE_DEPTH)) || pop);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign fill           = imem_rsp_valid & (drop_q == '0) & !redirect_valid;

  // outstanding includes old-stream requests still owed a response;
  // drop_cnt is the part of it that must be discarded.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      out_d  = out_q - CW'(imem_rsp_valid);
      drop_d = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .reserve_i    (req_fire),
    .reserve_pc_i (pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .head_valid_o (if_valid),
    .head_pc_o    (if_pc),
    .head_instr_o (if_instr),
    .reserved_o   (reserved)
  );

endmodule
